// File: rtl/tick_gen_mc.sv
// Multi-channel programmable tick / clock-enable generator.
// Each channel divides clk by a handshaked divisor, swapped in only at a period boundary.
module tick_gen_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 125000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_div_q [NUM_CH];
  logic [CNT_W-1:0]  pend_div_d [NUM_CH];
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0] out_q, out_d;

  logic [CNT_W-1:0]  cnt_nxt    [NUM_CH];
  logic [CNT_W-1:0]  half       [NUM_CH];
  logic [NUM_CH-1:0] wrap, apply, accept;
  logic [CNT_W-1:0]  div_clamped;

  // Out-of-range channels always look ready so their writes drain silently.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_vld_q[i];
    end
  end

  assign div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every variable gets a default first so no path through this block can infer a latch.
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      pend_div_d[i] = pend_div_q[i];
      pend_vld_d[i] = pend_vld_q[i];
      out_d[i]      = out_q[i];

      wrap[i]    = en[i] && (cnt_q[i] == div_act_q[i] - ONE);
      cnt_nxt[i] = wrap[i] ? '0 : cnt_q[i] + ONE;
      half[i]    = (div_act_q[i] >> 1) + {{(CNT_W-1){1'b0}}, div_act_q[i][0]};
      apply[i]   = sync_clr || !en[i] || wrap[i];
      accept[i]  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

      if (sync_clr || !en[i]) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_nxt[i];
        out_d[i] = mode[i] ? ((cnt_nxt[i] != '0) && (cnt_nxt[i] <= half[i])) : wrap[i];
      end

      // cfg_ready is low whenever pend_vld is set, so apply and accept never collide.
      if (apply[i] && pend_vld_q[i]) begin
        div_act_d[i]  = pend_div_q[i];
        pend_vld_d[i] = 1'b0;
      end else if (accept[i]) begin
        pend_div_d[i] = div_clamped;
        pend_vld_d[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all channels update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DIV_RST;
        pend_div_q[i] <= '0;
      end
      pend_vld_q <= '0;
      out_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        pend_div_q[i] <= pend_div_d[i];
      end
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_tick_gen_mc.sv
// Directed bench for tick_gen_mc: tick/square timing, divisor handshake, clamp, realign, reset.
module tb_tick_gen_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en, mode;
  logic        sync_clr, cfg_valid;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic [3:0]  out;

  // Second instance with a 3-bit channel select so an out-of-range channel is expressible.
  logic [4:0]  en5, mode5;
  logic        sync_clr5, cfg_valid5;
  logic [2:0]  cfg_ch5;
  logic [31:0] cfg_div5;
  logic        cfg_ready5;
  logic [4:0]  out5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tick_gen_mc #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .out(out)
  );

  tick_gen_mc #(.NUM_CH(5), .CNT_W(32), .DEFAULT_DIV(10)) u_oor (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .sync_clr(sync_clr5),
    .cfg_valid(cfg_valid5), .cfg_ch(cfg_ch5), .cfg_div(cfg_div5),
    .cfg_ready(cfg_ready5), .out(out5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Disabled channel: accept on one edge, pending divisor applied on the next.
  task automatic write_idle(input logic [1:0] ch, input logic [31:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = div;
    check($sformatf("wr_ready ch%0d", ch), cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  function automatic logic [3:0] exp_sync(input int k);
    logic [3:0] e;
    e[0] = (k % 6 == 0);
    e[1] = (k % 7 >= 1) && (k % 7 <= 4);
    e[2] = (k % 2 == 0);
    e[3] = (k % 10 == 0);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rise1, rise2;
    logic prev;

    rst_n = 1'b0; en = '0; mode = '0; sync_clr = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    en5 = '0; mode5 = '0; sync_clr5 = 1'b0;
    cfg_valid5 = 1'b0; cfg_ch5 = '0; cfg_div5 = '0;

    #12;
    check("rst_out", out, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_out5", out5, 0);
    rst_n = 1'b1;
    step();

    // ch0 tick mode at the default divisor of 10
    en = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("tick10 k=%0d", k), out, {3'b000, k % 10 == 0});
    end

    // ch0: write 4 at cnt=3, second write stalls until after the wrap
    step(); step(); step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd4;
    check("upd_ready_first", cfg_ready, 1);
    step();
    cfg_div = 32'd6;
    for (int j = 35; j <= 40; j++) begin
      check($sformatf("upd_stall j=%0d", j), cfg_ready, 0);
      step();
      check($sformatf("upd_old_period j=%0d", j), out[0], j == 40);
    end
    check("upd_ready_after_wrap", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("upd_second_pending", cfg_ready, 0);
    check("upd_out41", out[0], 0);
    for (int j = 42; j <= 50; j++) begin
      step();
      check($sformatf("upd_new_period j=%0d", j), out[0], (j == 44) || (j == 50));
    end

    // ch1: square mode, divisor 7 written while disabled
    mode[1] = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd7;
    check("sq_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("sq_pending", cfg_ready, 0);
    step();
    check("sq_applied_ready", cfg_ready, 1);
    check("sq_out_idle", out[1], 0);
    en[1] = 1'b1;
    prev = 1'b0; rise1 = -1; rise2 = -1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("sq7 k=%0d", k), out[1], (k % 7 >= 1) && (k % 7 <= 4));
      if (out[1] && !prev) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev = out[1];
    end
    check("sq7_period", rise2 - rise1, 7);

    // ch2: divisors 0 and 1 clamp to 2
    write_idle(2'd2, 32'd0);
    en[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("clamp0 k=%0d", k), out[2], k % 2 == 0);
    end
    en[2] = 1'b0;
    step();
    write_idle(2'd2, 32'd1);
    en[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("clamp1 k=%0d", k), out[2], k % 2 == 0);
    end

    // Out-of-range channel on the 5-channel instance: accepted, no effect
    en5 = 5'b11111;
    cfg_valid5 = 1'b1; cfg_ch5 = 3'd7; cfg_div5 = 32'd3;
    check("oor_ready", cfg_ready5, 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        cfg_valid5 = 1'b0;
        for (int c = 0; c < 5; c++) begin
          cfg_ch5 = 3'(c);
          #1;
          check($sformatf("oor_no_pending ch%0d", c), cfg_ready5, 1);
        end
      end
      check($sformatf("oor_out k=%0d", k), out5, (k % 10 == 0) ? 5'h1f : 5'h00);
    end

    // All channels at different phases, then realign with sync_clr
    en = 4'b1111; mode = 4'b0010;
    for (int k = 0; k < 5; k++) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("sync_out_clear", out, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("sync k=%0d", k), out, exp_sync(k));
    end

    // Pending write on ch3, then asynchronous reset mid-period
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd3;
    check("rst_wr_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    check("rst_wr_pending", cfg_ready, 0);
    check("rst_wr_k13", out, exp_sync(13));
    step();
    check("rst_wr_k14", out, exp_sync(14));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_ready", cfg_ready, 1);
    en = '0; mode = '0;
    #1;
    rst_n = 1'b1;
    step();
    en = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("post_rst k=%0d", k), out, {k % 10 == 0, 3'b000});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
